// File: rtl/i2c_master_burst.sv
// i2c_master_burst: I2C master that runs START, 7-bit address + R/W, a burst of
// 0..2**LEN_W-1 data bytes with per-byte acknowledge, then STOP.
// Each bit is four quarters of CLK_DIV clocks: q0 SCL low, q1/q2 SCL high, q3 SCL low.
module i2c_master_burst #(
   parameter int CLK_DIV = 4,
   parameter int LEN_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             rw,
   input  logic [6:0]       addr,
   input  logic [LEN_W-1:0] len,
   input  logic [7:0]       wr_data,
   output logic             wr_ready,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             busy,
   output logic             done,
   output logic             nack,
   output logic [2:0]       state,
   output logic             sclk,
   input  logic             sda_in,
   output logic             sda_out
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_START    = 3'd1,
      S_ADDR     = 3'd2,
      S_ADDR_ACK = 3'd3,
      S_WRITE    = 3'd4,
      S_READ     = 3'd5,
      S_DATA_ACK = 3'd6,
      S_STOP     = 3'd7
   } state_t;

   localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       qtr_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic [LEN_W-1:0] len_q;
   logic             rw_q;
   logic             samp_q;
   logic             wr_ready_q;
   logic [7:0]       rd_data_q;
   logic             rd_valid_q;
   logic             busy_q;
   logic             done_q;
   logic             nack_q;
   logic             sclk_q;
   logic             sda_q;
   logic             tick;

   // Last clock of the current quarter
   assign tick = (cnt_q == CNT_MAX);

   // Sequencer: quarter timing, SCL/SDA generation, shifting and byte accounting
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         qtr_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         len_q      <= '0;
         rw_q       <= 1'b0;
         samp_q     <= 1'b1;
         wr_ready_q <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         nack_q     <= 1'b0;
         sclk_q     <= 1'b1;
         sda_q      <= 1'b1;
      end else begin
         wr_ready_q <= 1'b0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         if (state_q == S_IDLE) begin
            cnt_q <= '0;
            qtr_q <= '0;
            if (start) begin
               state_q <= S_START;
               busy_q  <= 1'b1;
               nack_q  <= 1'b0;
               rw_q    <= rw;
               len_q   <= len;
               shift_q <= {addr, rw};
               bit_q   <= '0;
               sclk_q  <= 1'b1;
               sda_q   <= 1'b1;
            end
         end else begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
               qtr_q <= qtr_q + 2'd1;
               // End of q2: sample the bus; read bytes assemble here
               if (qtr_q == 2'd2) begin
                  samp_q <= sda_in;
                  if (state_q == S_READ) begin
                     shift_q <= {shift_q[6:0], sda_in};
                     if (bit_q == 3'd7) begin
                        rd_data_q  <= {shift_q[6:0], sda_in};
                        rd_valid_q <= 1'b1;
                     end
                  end
               end
               case (qtr_q)
                  2'd0: sclk_q <= 1'b1;
                  2'd1: begin
                     // START/STOP are the only places SDA moves with SCL high
                     if (state_q == S_START) sda_q <= 1'b0;
                     if (state_q == S_STOP)  sda_q <= 1'b1;
                  end
                  2'd2: if (state_q != S_STOP) sclk_q <= 1'b0;
                  default: begin
                     // Bit boundary: pick the next bit and put its SDA level out in q0
                     case (state_q)
                        S_START: begin
                           state_q <= S_ADDR;
                           bit_q   <= '0;
                           sda_q   <= shift_q[7];
                        end
                        S_ADDR, S_WRITE: begin
                           bit_q <= bit_q + 3'd1;
                           if (bit_q == 3'd7) begin
                              state_q <= (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                              sda_q   <= 1'b1;
                           end else begin
                              shift_q <= {shift_q[6:0], 1'b0};
                              sda_q   <= shift_q[6];
                           end
                        end
                        S_READ: begin
                           bit_q <= bit_q + 3'd1;
                           if (bit_q == 3'd7) begin
                              state_q <= S_DATA_ACK;
                              // ACK (0) while more bytes remain, NACK (1) on the last one
                              sda_q   <= (len_q == LEN_W'(1));
                           end
                        end
                        S_ADDR_ACK: begin
                           bit_q <= '0;
                           if (samp_q) begin
                              nack_q  <= 1'b1;
                              state_q <= S_STOP;
                              sda_q   <= 1'b0;
                           end else if (len_q == '0) begin
                              state_q <= S_STOP;
                              sda_q   <= 1'b0;
                           end else if (rw_q) begin
                              state_q <= S_READ;
                              sda_q   <= 1'b1;
                           end else begin
                              state_q    <= S_WRITE;
                              shift_q    <= wr_data;
                              sda_q      <= wr_data[7];
                              wr_ready_q <= 1'b1;
                           end
                        end
                        S_DATA_ACK: begin
                           bit_q <= '0;
                           if (!rw_q && samp_q) begin
                              nack_q  <= 1'b1;
                              state_q <= S_STOP;
                              sda_q   <= 1'b0;
                           end else begin
                              len_q <= len_q - LEN_W'(1);
                              if (len_q == LEN_W'(1)) begin
                                 state_q <= S_STOP;
                                 sda_q   <= 1'b0;
                              end else if (rw_q) begin
                                 state_q <= S_READ;
                                 sda_q   <= 1'b1;
                              end else begin
                                 state_q    <= S_WRITE;
                                 shift_q    <= wr_data;
                                 sda_q      <= wr_data[7];
                                 wr_ready_q <= 1'b1;
                              end
                           end
                        end
                        S_STOP: begin
                           state_q <= S_IDLE;
                           busy_q  <= 1'b0;
                           done_q  <= 1'b1;
                        end
                        default: state_q <= S_IDLE;
                     endcase
                  end
               endcase
            end
         end
      end
   end

   assign wr_ready = wr_ready_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign nack     = nack_q;
   assign state    = state_q;
   assign sclk     = sclk_q;
   assign sda_out  = sda_q;

endmodule

// File: tb/tb_i2c_master_burst.sv
// tb_i2c_master_burst: directed checks of i2c_master_burst with a bit-level slave model.
// dut0 runs with CLK_DIV=4, dut1 with CLK_DIV=1; sel routes one of them to the monitor.
`timescale 1ns/1ps
module tb_i2c_master_burst;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = '0;
   logic [3:0] len = '0;
   logic [7:0] wr_data = '0;
   logic       sda_in = 1'b1;
   logic       sel = 1'b0;

   logic       wr_ready0, rd_valid0, busy0, done0, nack0, sclk0, sda0;
   logic [7:0] rd_data0;
   logic [2:0] state0;
   logic       wr_ready1, rd_valid1, busy1, done1, nack1, sclk1, sda1;
   logic [7:0] rd_data1;
   logic [2:0] state1;

   i2c_master_burst #(.CLK_DIV(4), .LEN_W(4)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .rw(rw), .addr(addr), .len(len),
      .wr_data(wr_data), .wr_ready(wr_ready0), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .busy(busy0), .done(done0), .nack(nack0), .state(state0), .sclk(sclk0),
      .sda_in(sda_in), .sda_out(sda0)
   );

   i2c_master_burst #(.CLK_DIV(1), .LEN_W(4)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .rw(rw), .addr(addr), .len(len),
      .wr_data(wr_data), .wr_ready(wr_ready1), .rd_data(rd_data1), .rd_valid(rd_valid1),
      .busy(busy1), .done(done1), .nack(nack1), .state(state1), .sclk(sclk1),
      .sda_in(sda_in), .sda_out(sda1)
   );

   logic       sclk_m, sda_m, wr_ready_m, rd_valid_m, busy_m, done_m, nack_m;
   logic [2:0] state_m;
   logic [7:0] rd_data_m;
   assign sclk_m     = sel ? sclk1     : sclk0;
   assign sda_m      = sel ? sda1      : sda0;
   assign wr_ready_m = sel ? wr_ready1 : wr_ready0;
   assign rd_valid_m = sel ? rd_valid1 : rd_valid0;
   assign busy_m     = sel ? busy1     : busy0;
   assign done_m     = sel ? done1     : done0;
   assign nack_m     = sel ? nack1     : nack0;
   assign state_m    = sel ? state1    : state0;
   assign rd_data_m  = sel ? rd_data1  : rd_data0;

   // Slave response per bit after START (bit 0 = address MSB); 1 = released
   logic [63:0] resp = '1;
   // Master SDA captured at each SCL rising edge after START
   logic [63:0] cap = '0;
   logic [7:0]  rd_log [16];
   int cyc = 0, bitcnt = 0, wr_tot = 0, rd_tot = 0, viol = 0, hi = 0, last_hi = 0;
   logic prev_sclk = 1'b1, prev_sda = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor and slave: runs on the falling clk edge, away from DUT updates
   always @(negedge clk) begin
      if (prev_sclk && sclk_m && prev_sda && !sda_m) bitcnt = 0;
      if (prev_sclk && sclk_m && (prev_sda != sda_m) && state_m != 3'd1 && state_m != 3'd7)
         viol++;
      if (!prev_sclk && sclk_m && bitcnt < 64) begin
         cap[bitcnt[5:0]] = sda_m;
         bitcnt++;
      end
      if (prev_sclk && !sclk_m) begin
         sda_in = (bitcnt < 64) ? resp[bitcnt[5:0]] : 1'b1;
         if (state_m == 3'd2) last_hi = hi;
      end
      hi = sclk_m ? hi + 1 : 0;
      if (wr_ready_m) wr_tot++;
      if (rd_valid_m && rd_tot < 16) begin
         rd_log[rd_tot[3:0]] = rd_data_m;
         rd_tot++;
      end
      prev_sclk = sclk_m;
      prev_sda  = sda_m;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] cap_byte(input int pos);
      logic [7:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         int k;
         k = pos + i;
         b = {b[6:0], cap[k[5:0]]};
      end
      return b;
   endfunction

   task automatic put_byte(input int pos, input logic [7:0] val);
      logic [7:0] b;
      b = val;
      for (int i = 0; i < 8; i++) begin
         int k;
         k = pos + i;
         resp[k[5:0]] = b[7];
         b = {b[6:0], 1'b0};
      end
   endtask

   // Start one transaction and wait (bounded) for done; lat = -1 on timeout
   task automatic run(input logic which, input logic r, input logic [6:0] a, input logic [3:0] n,
                      output int lat, output logic nk_acc, output logic bz_acc,
                      output logic bz_done);
      int t0;
      sel = which; rw = r; addr = a; len = n;
      @(posedge clk); #1;
      if (which) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      t0 = cyc; nk_acc = nack_m; bz_acc = busy_m;
      lat = -1; bz_done = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done_m) begin
            lat = cyc - t0;
            bz_done = busy_m;
            break;
         end
      end
   endtask

   int   lat, wr0, rd0;
   logic nk, bz, bzd;

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_sclk", sclk_m, 1);
      check("rst_sda", sda_m, 1);
      check("rst_state", state_m, 0);
      check("rst_busy", busy_m, 0);
      check("rst_done", done_m, 0);
      check("rst_nack", nack_m, 0);
      check("rst_wr_ready", wr_ready_m, 0);
      check("rst_rd_valid", rd_valid_m, 0);
      check("rst_rd_data", rd_data_m, 0);
      check("rst_sclk_div1", sclk1, 1);
      rst = 1'b0;

      // T1: write 0x50, A5 3C, slave ACKs; a start pulse mid-transfer is ignored
      resp = '1; resp[8] = 1'b0; resp[17] = 1'b0; resp[26] = 1'b0;
      wr_data = 8'hA5; wr0 = wr_tot; rd0 = rd_tot;
      fork
         run(1'b0, 1'b0, 7'h50, 4'd2, lat, nk, bz, bzd);
         begin
            repeat (60) @(posedge clk);
            #1;
            addr = 7'h7F; start0 = 1'b1;
            @(posedge clk); #1;
            start0 = 1'b0;
            for (int i = 0; i < 2000; i++) begin
               @(negedge clk);
               if (wr_ready_m) break;
            end
            @(posedge clk); #1;
            wr_data = 8'h3C;
         end
      join
      check("t1_latency", lat, 464);
      check("t1_addr_byte", cap_byte(0), 8'hA0);
      check("t1_addr_ack_released", cap[8], 1);
      check("t1_byte0", cap_byte(9), 8'hA5);
      check("t1_byte1", cap_byte(18), 8'h3C);
      check("t1_ack1_released", cap[26], 1);
      check("t1_wr_ready_count", wr_tot - wr0, 2);
      check("t1_rd_valid_count", rd_tot - rd0, 0);
      check("t1_nack", nack_m, 0);
      check("t1_busy_after_accept", bz, 1);
      check("t1_busy_at_done", bzd, 0);
      check("t1_state_at_done", state_m, 0);

      // T2: read 0x50, slave returns F6 then 81
      resp = '1; resp[8] = 1'b0;
      put_byte(9, 8'hF6); put_byte(18, 8'h81);
      wr0 = wr_tot; rd0 = rd_tot;
      run(1'b0, 1'b1, 7'h50, 4'd2, lat, nk, bz, bzd);
      check("t2_latency", lat, 464);
      check("t2_addr_byte", cap_byte(0), 8'hA1);
      check("t2_rd_valid_count", rd_tot - rd0, 2);
      check("t2_rd0", rd_log[rd0[3:0]], 8'hF6);
      check("t2_rd1", rd_log[4'(rd0 + 1)], 8'h81);
      check("t2_master_ack", cap[17], 0);
      check("t2_master_nack", cap[26], 1);
      check("t2_rd_data_held", rd_data_m, 8'h81);
      check("t2_nack", nack_m, 0);
      check("t2_wr_ready_count", wr_tot - wr0, 0);

      // T3: address NACKed
      resp = '1; wr_data = 8'hA5;
      wr0 = wr_tot; rd0 = rd_tot;
      run(1'b0, 1'b0, 7'h50, 4'd2, lat, nk, bz, bzd);
      check("t3_latency", lat, 176);
      check("t3_nack", nack_m, 1);
      check("t3_wr_ready_count", wr_tot - wr0, 0);
      check("t3_rd_valid_count", rd_tot - rd0, 0);

      // T4: len=0 probe with ACK; accepting it clears the sticky nack
      resp = '1; resp[8] = 1'b0;
      wr0 = wr_tot; rd0 = rd_tot;
      run(1'b0, 1'b0, 7'h2A, 4'd0, lat, nk, bz, bzd);
      check("t4_nack_cleared_on_start", nk, 0);
      check("t4_latency", lat, 176);
      check("t4_addr_byte", cap_byte(0), 8'h54);
      check("t4_strobes", (wr_tot - wr0) + (rd_tot - rd0), 0);
      check("t4_nack", nack_m, 0);
      check("sda_change_with_scl_high", viol, 0);

      // T5: reset during READ
      resp = '1; resp[8] = 1'b0;
      sel = 1'b0; rw = 1'b1; addr = 7'h50; len = 4'd2;
      @(posedge clk); #1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (state_m == 3'd5) break;
      end
      check("t5_reached_read", state_m, 5);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("t5_sclk", sclk_m, 1);
      check("t5_sda", sda_m, 1);
      check("t5_state", state_m, 0);
      check("t5_busy", busy_m, 0);
      rst = 1'b0;

      // T6: CLK_DIV=1 write of one byte C3
      resp = '1; resp[8] = 1'b0; resp[17] = 1'b0;
      wr_data = 8'hC3; wr0 = wr_tot;
      run(1'b1, 1'b0, 7'h50, 4'd1, lat, nk, bz, bzd);
      check("t6_latency", lat, 80);
      check("t6_scl_high_clks", last_hi, 2);
      check("t6_addr_byte", cap_byte(0), 8'hA0);
      check("t6_byte0", cap_byte(9), 8'hC3);
      check("t6_wr_ready_count", wr_tot - wr0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
